// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } sar_state_t;

  // Width of the bit-index counter; at least one bit so the counter
  // always exists even for the smallest legal code width.
  function automatic int sar_idx_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sar_ctrl.sv
// Successive-approximation sequencer driving an external magnitude
// comparator. One code bit is resolved per step, MSB first.
// Optional build macro SAR_SETTLE_EN: each bit takes a SETTLE cycle
// (flags ignored) followed by a DECIDE cycle (flags sampled), for a
// registered DAC or comparator in the loop.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = sar_idx_w(WIDTH);

  localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    IDX_MSB   = IW'(WIDTH-1);

  sar_state_t        state;
  logic [IW-1:0]     idx;
  logic              keep;
  logic              decide;
  logic [WIDTH-1:0]  trial_step;

  // a >= trial; both flags high is simply a keep
  assign keep = cmp_gt | cmp_eq;

`ifdef SAR_SETTLE_EN
  // Low during the SETTLE half of a bit, high during DECIDE
  logic settle;
  assign decide = settle;
`else
  assign decide = 1'b1;
`endif

  // Trial after resolving bit idx and, if any bits remain, probing the next one
  always_comb begin
    trial_step      = trial;
    trial_step[idx] = keep;
    if (idx != '0)
      trial_step[idx - 1'b1] = 1'b1;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      trial  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef SAR_SETTLE_EN
      settle <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= CONV;
            trial <= TRIAL_MSB;
            idx   <= IDX_MSB;
            busy  <= 1'b1;
`ifdef SAR_SETTLE_EN
            settle <= 1'b0;
`endif
          end
        end
        CONV: begin
`ifdef SAR_SETTLE_EN
          settle <= ~settle;
`endif
          if (decide) begin
            if (idx != '0) begin
              trial <= trial_step;
              idx   <= idx - 1'b1;
            end else begin
              result <= trial_step;
              trial  <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          trial <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl (WIDTH=4) with a behavioural comparator.
// Honours SAR_SETTLE_EN when the design is built with it.
module tb_sar_ctrl;

  localparam int W = 4;
`ifdef SAR_SETTLE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int LAT = W * STEP + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cmp_gt;
  logic         cmp_eq;
  logic [W-1:0] trial;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  logic [W-1:0] a;
  logic         ovr;   // force both comparator flags high

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Comparator sitting beside the controller
  assign cmp_gt = ovr | (a > trial);
  assign cmp_eq = ovr | (a == trial);

  sar_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One pulsed conversion; trials packed MSB-first step order
  task automatic run_conv(input logic [W-1:0] av, input logic [4*W-1:0] trials,
                          input logic [W-1:0] res);
    a = av;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);                 // edge 0
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy", busy, 1);
      chk("done", done, (c == LAT));
      if (c < LAT)
        chk("trial", trial, trials[4*W-1 - W*((c-1)/STEP) -: W]);
      else begin
        chk("result", result, res);
        chk("trial_done", trial, 0);
      end
    end
    @(negedge clk);
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    chk("result_hold", result, res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; ovr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_trial", trial, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(4'b1010, {4'b1000, 4'b1100, 4'b1010, 4'b1011}, 4'b1010);
    run_conv(4'b1111, {4'b1000, 4'b1100, 4'b1110, 4'b1111}, 4'b1111);
    run_conv(4'b0000, {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4'b0000);
    run_conv(4'b0101, {4'b1000, 4'b0100, 4'b0110, 4'b0101}, 4'b0101);

    // Both flags high resolves every bit as kept
    ovr = 1'b1;
    run_conv(4'b0000, {4'b1000, 4'b1100, 4'b1110, 4'b1111}, 4'b1111);
    ovr = 1'b0;

    // start held high: back-to-back conversions every LAT+1 cycles
    a = 4'b0110;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("held_done", done, ((c % (LAT + 1)) == LAT));
      if ((c % (LAT + 1)) == LAT) chk("held_result", result, 4'b0110);
      chk("held_busy", busy, ((c % (LAT + 1)) != 0));
    end
    start = 1'b0;
    repeat (2 * LAT + 2) @(negedge clk);
    chk("held_idle", busy, 0);
    chk("held_last", result, 4'b0110);

    // Reset in cycle 2 of a conversion aborts and clears everything
    a = 4'b1010;
    start = 1'b1;
    @(posedge clk);                 // edge 0
    @(negedge clk);                 // cycle 1
    start = 1'b0;
    chk("abort_c1", trial, 4'b1000);
    @(negedge clk);                 // cycle 2
    rst = 1'b1;
    @(negedge clk);                 // cycle 3
    rst = 1'b0;
    chk("abort_trial", trial, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end

    // rst and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_trial", trial, 0);

    run_conv(4'b1010, {4'b1000, 4'b1100, 4'b1010, 4'b1011}, 4'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
